// File: rtl/outerprodrc_reader.sv
// Clear/run/readout sequencer for the outerprodrc rate-coded outer-product array.
// Optional macro OUTERPRODRC_READER_SKIPZERO_EN: drain presents only nonzero entries.
module outerprodrc_reader #(
    parameter int ROWNUM      = 2,
    parameter int COLNUM      = 2,
    parameter int BITWIDTH    = 4,
    parameter int OUTBITWIDTH = 8,
    localparam int RW = (ROWNUM > 1) ? $clog2(ROWNUM) : 1,
    localparam int CW = (COLNUM > 1) ? $clog2(COLNUM) : 1
) (
    input  logic                                 iClk,
    input  logic                                 iRstN,
    input  logic                                 iStart,
    output logic                                 oBusy,
    output logic                                 oEn,
    output logic                                 oClr,
    input  logic [ROWNUM*COLNUM*OUTBITWIDTH-1:0] iData,
    output logic                                 oValid,
    input  logic                                 iReady,
    output logic [OUTBITWIDTH-1:0]               oData,
    output logic [RW-1:0]                        oRow,
    output logic [CW-1:0]                        oCol,
    output logic                                 oLast,
    output logic                                 oDone
);
    localparam int N  = 1 << (BITWIDTH - 1);
    localparam int NE = ROWNUM * COLNUM;
    localparam int IW = (NE > 1) ? $clog2(NE) : 1;

    typedef enum logic [2:0] {IDLE, CLR, RUN, SETTLE, DRAIN} state_t;

    state_t                     state, state_nxt;
    logic [BITWIDTH-1:0]        run_cnt;
    logic [NE*OUTBITWIDTH-1:0]  shadow;
    logic [NE*OUTBITWIDTH-1:0]  src;
    logic [IW-1:0]              idx;
    logic                       hs;
    logic                       found;
    logic                       last;
    int                         start_i;
    int                         sel;

    assign hs = oValid & iReady;

    // Entry selection: the snapshot is taken from the live bus on the SETTLE
    // edge, afterwards only the shadow copy is consulted.
    always_comb begin
        src     = shadow;
        start_i = int'(idx) + 1;
        if (state == SETTLE) begin
            src     = iData;
            start_i = 0;
        end
`ifdef OUTERPRODRC_READER_SKIPZERO_EN
        found = 1'b0;
        sel   = 0;
        for (int k = NE - 1; k >= 0; k--) begin
            if (k >= start_i && src[k*OUTBITWIDTH +: OUTBITWIDTH] != '0) begin
                found = 1'b1;
                sel   = k;
            end
        end
        last = 1'b1;
        for (int k = 0; k < NE; k++) begin
            if (k > sel && src[k*OUTBITWIDTH +: OUTBITWIDTH] != '0) last = 1'b0;
        end
`else
        found = (start_i < NE);
        sel   = start_i;
        last  = (start_i == NE - 1);
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (iStart) state_nxt = CLR;
            CLR:     state_nxt = RUN;
            RUN:     if (run_cnt == BITWIDTH'(N - 1)) state_nxt = SETTLE;
            SETTLE:  state_nxt = found ? DRAIN : IDLE;
            DRAIN:   if (hs && oLast) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) state <= IDLE;
        else        state <= state_nxt;
    end

    // Control outputs are registered from the next state so they line up with it.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            oBusy   <= 1'b0;
            oEn     <= 1'b0;
            oClr    <= 1'b0;
            oDone   <= 1'b0;
            run_cnt <= '0;
        end else begin
            oBusy   <= (state_nxt != IDLE);
            oEn     <= (state_nxt == RUN);
            oClr    <= (state_nxt == CLR);
            oDone   <= (state != IDLE) && (state_nxt == IDLE);
            run_cnt <= (state == RUN) ? run_cnt + 1'b1 : '0;
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            shadow <= '0;
            idx    <= '0;
            oValid <= 1'b0;
            oData  <= '0;
            oRow   <= '0;
            oCol   <= '0;
            oLast  <= 1'b0;
        end else if (state == SETTLE || (state == DRAIN && hs)) begin
            if (state == SETTLE) shadow <= iData;
            if (state_nxt == DRAIN) begin
                oValid <= 1'b1;
                idx    <= IW'(sel);
                oData  <= src[sel*OUTBITWIDTH +: OUTBITWIDTH];
                oRow   <= RW'(sel / COLNUM);
                oCol   <= CW'(sel % COLNUM);
                oLast  <= last;
            end else begin
                oValid <= 1'b0;
                idx    <= '0;
                oData  <= '0;
                oRow   <= '0;
                oCol   <= '0;
                oLast  <= 1'b0;
            end
        end
    end

endmodule
